branch_condition_unit: RTL and testbench
========================================

BRANCH_CONDITION_UNIT -- requirements
Module: branch_condition_unit

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: flags  input  6  current processor status register contents: bit0 C, bit1 Z, bit2 L, bit3 F, bit4 N, bit5 reserved and ignored.
REQ-004 SHALL have port: flags_next  input  6  flag value the status register captures at the next edge; same bit layout as flags.
REQ-005 SHALL have port: flags_we  input  1  status register update occurs at the next edge.
REQ-006 SHALL have port: flags_pending  input  1  a flag-setting instruction is in flight and has not yet written flags.
REQ-007 SHALL have port: req_valid  input  1  branch condition request.
REQ-008 SHALL have port: req_ready  output  1  request accepted this cycle when req_valid is also 1.
REQ-009 SHALL have port: req_cond  input  4  condition code.
REQ-010 SHALL have port: resp_valid  output  1  result available.
REQ-011 SHALL have port: resp_taken  output  1  condition true.
REQ-012 SHALL have port: resp_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port: count_clr  input  1  synchronous clear of taken_count.
REQ-014 SHALL have port: taken_count  output  8  count of taken results delivered.

Function
REQ-015 SHALL decode req_cond as: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; 10 LO !L&!Z; 11 HS L|Z; 12 LT !N&!Z; 13 GE N|Z; 14 UC always 1; 15 NV always 0.
REQ-016 SHALL implement FSM states IDLE, WAIT_FLAGS and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE, accept a request when req_valid=1 and latch req_cond.
REQ-019 SHALL, on accept with flags_pending=0 and flags_we=0, evaluate against flags and enter RESP, giving resp_valid=1 exactly one cycle after accept.
REQ-020 SHALL, on accept with flags_pending=1, or with flags_we=1 when FLAG_FORWARD_EN is undefined, enter WAIT_FLAGS.
REQ-021 SHALL stay in WAIT_FLAGS while flags_pending=1 or flags_we=1, then evaluate against flags in the first cycle both are 0 and enter RESP at the next edge.
REQ-022 SHALL, in RESP, hold resp_valid=1 and a stable resp_taken until resp_ready=1, then return to IDLE.
REQ-023 SHALL NOT accept a new request in the cycle it returns to IDLE; back-to-back throughput is one request per two cycles.
REQ-024 SHALL increment taken_count on each RESP handshake with resp_taken=1, saturating at 255.
REQ-025 SHALL give count_clr priority over an increment in the same cycle.
REQ-026 SHALL never change resp_taken while resp_valid=1.

Reset
REQ-027 SHALL, on reset_n=0, immediately force state IDLE, resp_valid=0, resp_taken=0, taken_count=0 and the latched condition=0.
REQ-028 SHALL abort an in-flight request on reset mid-operation, with no response issued after reset_n returns to 1.
REQ-029 SHALL drive req_ready=1 in the first cycle after reset_n deasserts.

Configuration
REQ-030 SHALL, with FLAG_FORWARD_EN defined, evaluate against flags_next when accepting with flags_we=1 and flags_pending=0, entering RESP directly with 1-cycle latency, and SHALL also exit WAIT_FLAGS in the cycle flags_we=1 with flags_pending=0, using flags_next.
REQ-031 SHALL, without FLAG_FORWARD_EN, never read flags_next, which is then unused.

Structure
REQ-032 SHALL place the condition-code constants, the flag bit indices and the FSM state encoding in a shared package also used by the ALU and the status register.
REQ-033 SHALL implement the REQ-015 decode as combinational sub-module cond_eval (inputs cond[3:0] and flags[5:0], output taken).

Verification
REQ-034 SHALL check: flags=6'b000010, req_cond=0 accepted, resp_ready=1 -> resp_valid next cycle, resp_taken=1, taken_count=1.
REQ-035 SHALL check: flags=0, req_cond=12 (LT) -> taken=1; req_cond=13 (GE) -> taken=0; req_cond=15 -> taken=0 for all 64 flag values.
REQ-036 SHALL check: flags_pending=1 for 3 cycles after accept -> resp_valid 4 cycles after accept, evaluated on updated flags.
REQ-037 SHALL check: accept with flags_we=1, flags_next Z=1, cond EQ -> 1-cycle latency and taken=1 with FLAG_FORWARD_EN, 2-cycle latency without.
REQ-038 SHALL check: resp_ready held 0 for 5 cycles -> resp_valid and resp_taken stable, req_ready=0; 300 taken handshakes -> taken_count=255; count_clr together with an increment -> 0.
REQ-039 SHALL check: reset_n=0 pulse while in WAIT_FLAGS -> resp_valid=0 immediately, no response afterwards, req_ready=1 after release.

Source files
------------

// File: rtl/branch_condition_unit_pkg.sv
// rtl/branch_condition_unit_pkg.sv - shared condition codes, flag bit indices and FSM encoding
// Shared with the ALU and the status register so every block agrees on the
// flag layout and the branch condition numbering.
package branch_condition_unit_pkg;

    // Status register bit positions; bit 5 is reserved and never decoded.
    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_L    = 2;
    localparam int FLAG_F    = 3;
    localparam int FLAG_N    = 4;
    localparam int FLAG_RSVD = 5;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_HI = 4'd4,
        COND_LS = 4'd5,
        COND_GT = 4'd6,
        COND_LE = 4'd7,
        COND_FS = 4'd8,
        COND_FC = 4'd9,
        COND_LO = 4'd10,
        COND_HS = 4'd11,
        COND_LT = 4'd12,
        COND_GE = 4'd13,
        COND_UC = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    // Branch unit FSM encoding.
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FLAGS = 2'd1;
    localparam logic [1:0] ST_RESP       = 2'd2;

endpackage

// File: rtl/branch_condition_unit_if.sv
// rtl/branch_condition_unit_if.sv - request/response handshake bundle of the branch condition unit
// Request : req_valid, req_ready, req_cond[3:0]
// Response: resp_valid, resp_ready, resp_taken
// master = branch issuer, slave = branch_condition_unit.
interface branch_condition_unit_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_cond;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_taken;

    modport master (
        output req_valid, req_cond, resp_ready,
        input  req_ready, resp_valid, resp_taken
    );

    modport slave (
        input  req_valid, req_cond, resp_ready,
        output req_ready, resp_valid, resp_taken
    );
endinterface

// File: rtl/branch_condition_unit_cond_eval.sv
// rtl/branch_condition_unit_cond_eval.sv - combinational branch condition decode
// Ports: cond[3:0] condition code, flags[5:0] status bits, taken = condition true.
module cond_eval
    import branch_condition_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [5:0] flags,
    output logic       taken
);

    logic c, z, l, f, n;
    assign c = flags[FLAG_C];
    assign z = flags[FLAG_Z];
    assign l = flags[FLAG_L];
    assign f = flags[FLAG_F];
    assign n = flags[FLAG_N];

    // Reserved bit has no meaning for any condition.
    logic unused_rsvd;
    assign unused_rsvd = flags[FLAG_RSVD];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_HI: taken = l;
            COND_LS: taken = !l;
            COND_GT: taken = n;
            COND_LE: taken = !n;
            COND_FS: taken = f;
            COND_FC: taken = !f;
            COND_LO: taken = !l && !z;
            COND_HS: taken = l || z;
            COND_LT: taken = !n && !z;
            COND_GE: taken = n || z;
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_condition_unit.sv
// rtl/branch_condition_unit.sv - branch condition evaluator with flag interlock and taken counter
// Ports: clock, reset_n (async active-low), flags/flags_next[5:0], flags_we,
//        flags_pending, count_clr, taken_count[7:0], bus (slave handshake).
// Option: FLAG_FORWARD_EN forwards flags_next while a status write is landing.
module branch_condition_unit
    import branch_condition_unit_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [5:0]            flags,
    input  logic [5:0]            flags_next,
    input  logic                  flags_we,
    input  logic                  flags_pending,
    input  logic                  count_clr,
    output logic [7:0]            taken_count,
    branch_condition_unit_if.slave bus
);

    logic [1:0] state_q, state_d;
    logic [3:0] cond_q, cond_d;
    logic       taken_q, taken_d;
    logic [7:0] count_q, count_d;

    logic [3:0] eval_cond;
    logic [5:0] eval_flags;
    logic       eval_taken;

    cond_eval u_cond_eval (
        .cond  (eval_cond),
        .flags (eval_flags),
        .taken (eval_taken)
    );

`ifndef FLAG_FORWARD_EN
    logic unused_flags_next;
    assign unused_flags_next = &{1'b0, flags_next};
`endif

    always_comb begin
        state_d    = state_q;
        cond_d     = cond_q;
        taken_d    = taken_q;
        eval_cond  = cond_q;
        eval_flags = flags;
        case (state_q)
            ST_IDLE: begin
                // Evaluate the incoming code directly so a clean accept
                // responds one cycle later without a detour through cond_q.
                eval_cond = bus.req_cond;
                if (bus.req_valid) begin
                    cond_d = bus.req_cond;
                    if (!flags_pending && !flags_we) begin
                        taken_d = eval_taken;
                        state_d = ST_RESP;
                    end
`ifdef FLAG_FORWARD_EN
                    else if (!flags_pending) begin
                        eval_flags = flags_next;
                        taken_d    = eval_taken;
                        state_d    = ST_RESP;
                    end
`endif
                    else begin
                        state_d = ST_WAIT_FLAGS;
                    end
                end
            end
            ST_WAIT_FLAGS: begin
                if (!flags_pending && !flags_we) begin
                    taken_d = eval_taken;
                    state_d = ST_RESP;
                end
`ifdef FLAG_FORWARD_EN
                else if (!flags_pending) begin
                    eval_flags = flags_next;
                    taken_d    = eval_taken;
                    state_d    = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                // taken_q is only written outside RESP, so it cannot move
                // while the response is being offered.
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = 8'd0;
        end else if (state_q == ST_RESP && bus.resp_ready && taken_q && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cond_q  <= 4'd0;
            taken_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            taken_q <= taken_d;
            count_q <= count_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_taken = taken_q;
    assign taken_count    = count_q;

endmodule

// File: tb/tb_branch_condition_unit.sv
// tb/tb_branch_condition_unit.sv - directed self-checking bench for branch_condition_unit
module tb_branch_condition_unit;

    logic       clock;
    logic       reset_n;
    logic [5:0] flags;
    logic [5:0] flags_next;
    logic       flags_we;
    logic       flags_pending;
    logic       count_clr;
    logic [7:0] taken_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    branch_condition_unit_if bus ();

    branch_condition_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .flags         (flags),
        .flags_next    (flags_next),
        .flags_we      (flags_we),
        .flags_pending (flags_pending),
        .count_clr     (count_clr),
        .taken_count   (taken_count),
        .bus           (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clean request with resp_ready already high: response one cycle
    // after accept, handshake on the following edge.
    task automatic single(input logic [3:0] c, input logic [5:0] f, input logic exp, input string tag);
        bus.req_valid  = 1'b1;
        bus.req_cond   = c;
        bus.resp_ready = 1'b1;
        flags          = f;
        tick();
        bus.req_valid = 1'b0;
        chk({tag, "_vld"}, {31'd0, bus.resp_valid}, 32'd1);
        chk({tag, "_tkn"}, {31'd0, bus.resp_taken}, {31'd0, exp});
        chk({tag, "_nrdy"}, {31'd0, bus.req_ready}, 32'd0);
        tick();
        if (exp && exp_cnt < 255) exp_cnt++;
        chk({tag, "_cnt"}, {24'd0, taken_count}, exp_cnt);
    endtask

    logic [15:0] tbl_map  [4];
    logic [5:0]  tbl_flag [4];

    initial begin
        reset_n        = 1'b0;
        flags          = 6'd0;
        flags_next     = 6'd0;
        flags_we       = 1'b0;
        flags_pending  = 1'b0;
        count_clr      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_cond   = 4'd0;
        bus.resp_ready = 1'b0;

        // Hand-derived truth bitmaps, bit i = condition code i.
        tbl_flag[0] = 6'b000000; tbl_map[0] = 16'h56AA;
        tbl_flag[1] = 6'b011111; tbl_map[1] = 16'h6955;
        tbl_flag[2] = 6'b100100; tbl_map[2] = 16'h5A9A;
        tbl_flag[3] = 6'b010010; tbl_map[3] = 16'h6A69;

        #2;
        chk("rst_vld", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_tkn", {31'd0, bus.resp_taken}, 32'd0);
        chk("rst_cnt", {24'd0, taken_count}, 32'd0);
        tick();
        reset_n = 1'b1;
        chk("rel_rdy", {31'd0, bus.req_ready}, 32'd1);

        // EQ with Z set
        single(4'd0, 6'b000010, 1'b1, "eq_z");
        chk("eq_z_idle", {31'd0, bus.req_ready}, 32'd1);

        single(4'd12, 6'd0, 1'b1, "lt_0");
        single(4'd13, 6'd0, 1'b0, "ge_0");

        for (int i = 0; i < 64; i++) begin
            single(4'd15, i[5:0], 1'b0, "nv_all");
        end

        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 16; c++) begin
                single(c[3:0], tbl_flag[t], tbl_map[t][c], $sformatf("dec_t%0d_c%0d", t, c));
            end
        end

        // Pending interlock: three pending cycles after accept.
        bus.req_valid = 1'b1;
        bus.req_cond  = 4'd0;
        flags         = 6'd0;
        flags_pending = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("pend_wait_vld", {31'd0, bus.resp_valid}, 32'd0);
            chk("pend_wait_rdy", {31'd0, bus.req_ready}, 32'd0);
            tick();
        end
        flags_pending = 1'b0;
        flags         = 6'b000010;
        chk("pend_still_wait", {31'd0, bus.resp_valid}, 32'd0);
        tick();
        chk("pend_vld4", {31'd0, bus.resp_valid}, 32'd1);
        chk("pend_tkn", {31'd0, bus.resp_taken}, 32'd1);
        tick();
        exp_cnt++;
        chk("pend_cnt", {24'd0, taken_count}, exp_cnt);

        // Accept while the status write is landing.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_cond   = 4'd0;
        flags          = 6'd0;
        flags_next     = 6'b000010;
        flags_we       = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        flags_we      = 1'b0;
        flags         = flags_next;
`ifdef FLAG_FORWARD_EN
        chk("fwd_vld1", {31'd0, bus.resp_valid}, 32'd1);
        chk("fwd_tkn1", {31'd0, bus.resp_taken}, 32'd1);
`else
        chk("fwd_vld1", {31'd0, bus.resp_valid}, 32'd0);
`endif
        tick();
        chk("fwd_vld2", {31'd0, bus.resp_valid}, 32'd1);
        chk("fwd_tkn2", {31'd0, bus.resp_taken}, 32'd1);
        bus.resp_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("fwd_cnt", {24'd0, taken_count}, exp_cnt);

        // Back-pressure: response must hold while new requests are offered.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_cond   = 4'd14;
        tick();
        bus.req_cond = 4'd15;
        for (int i = 0; i < 5; i++) begin
            flags = i[5:0];
            chk("bp_vld", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_tkn", {31'd0, bus.resp_taken}, 32'd1);
            chk("bp_rdy", {31'd0, bus.req_ready}, 32'd0);
            tick();
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_cnt", {24'd0, taken_count}, exp_cnt);

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            bus.req_valid = 1'b1;
            bus.req_cond  = 4'd14;
            tick();
            bus.req_valid = 1'b0;
            tick();
        end
        exp_cnt = 255;
        chk("sat_cnt", {24'd0, taken_count}, 32'd255);

        // Clear wins over a simultaneous increment.
        bus.req_valid = 1'b1;
        bus.req_cond  = 4'd14;
        tick();
        bus.req_valid = 1'b0;
        chk("clr_vld", {31'd0, bus.resp_valid}, 32'd1);
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        exp_cnt   = 0;
        chk("clr_cnt", {24'd0, taken_count}, 32'd0);
        single(4'd14, 6'd0, 1'b1, "post_clr");

        // Reset while waiting on flags.
        bus.req_valid = 1'b1;
        bus.req_cond  = 4'd14;
        flags_pending = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("rw_wait", {31'd0, bus.resp_valid}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rw_vld", {31'd0, bus.resp_valid}, 32'd0);
        chk("rw_rdy", {31'd0, bus.req_ready}, 32'd1);
        chk("rw_cnt", {24'd0, taken_count}, 32'd0);
        tick();
        reset_n       = 1'b1;
        flags_pending = 1'b0;
        chk("rw_rel_rdy", {31'd0, bus.req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rw_no_resp", {31'd0, bus.resp_valid}, 32'd0);
            chk("rw_idle", {31'd0, bus.req_ready}, 32'd1);
        end
        single(4'd1, 6'd0, 1'b1, "rw_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
